float_to_int: RTL and testbench
===============================

Name: float_to_int

Overview:
- Converts one IEEE-754 single-precision value into an OUT_WIDTH-bit two's-complement integer. Saturates on overflow and returns 0 for NaN.
- Sits at the output of the ADS1292 float filter chain, in the int-to-float direction reversed: float results go back to integer sample format for the downstream UART/SPI packers.
- Uses the same STB/ACK operand/result handshake as the float arithmetic units. It can be chained directly after them.

Parameters:
OUT_WIDTH, 24, output integer width in bits (2..32); results saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
ROUND_MODE, 1, 0 = truncate toward zero, 1 = round to nearest, ties to even

Ports:
i_CLK  input  1  clock, rising edge
i_RST  input  1  reset, asynchronous, active-high
i_A  input  32  IEEE single operand
i_A_STB  input  1  operand valid
o_A_ACK  output  1  block ready to accept an operand
o_Z  output  OUT_WIDTH  signed integer result
o_Z_STB  output  1  result valid
i_Z_ACK  input  1  consumer has taken the result

Behaviour:
- Clocking and reset: one clock, i_CLK. i_RST is asynchronous and active-high.
- Reset values: state=GET_A, o_A_ACK=0, o_Z_STB=0, o_Z=0, all internal registers 0. o_A_ACK rises on the first i_CLK edge after i_RST deasserts.
- Reset asserted mid-operation aborts the conversion immediately. No result is emitted.
- States: GET_A, UNPACK, SPECIAL, SHIFT, ROUND, PACK, PUT_Z.
- GET_A:
  - Drive o_A_ACK=1.
  - On an edge where o_A_ACK && i_A_STB, latch i_A, drive o_A_ACK<=0 and go to UNPACK.
  - i_A is ignored in every other state.
- UNPACK:
  - Split the operand into sign s, biased exponent E, mantissa M[22:0].
  - Form e = E-127 (10-bit signed) and mag = {1,M}, 24 bits.
  - Go to SPECIAL.
- SPECIAL, checked in this priority order:
  - E==255 and M!=0 (NaN) -> result 0, go to PUT_Z.
  - E==255 and M==0 (±inf) -> saturate by sign, go to PUT_Z.
  - E==0 (zero or denormal, |x|<2^-126) -> result 0, go to PUT_Z. Negative zero gives 0.
  - Otherwise go to SHIFT.
- SHIFT (single-cycle barrel shifter; magnitude register is at least 33 bits):
  - e>=23: mag <<= (e-23), guard=0, sticky=0.
  - 0<=e<23: mag >>= (23-e). guard = last bit shifted out. sticky = OR of all lower shifted-out bits.
  - e==-1: mag=0, guard=1, sticky=(M!=0).
  - e<-1: mag=0, guard=0, sticky=1.
  - Flag ovf = (e >= 31), so the shift never exceeds register width.
- ROUND:
  - ROUND_MODE=1: if guard && (sticky || mag[0]) then mag=mag+1.
  - ROUND_MODE=0: no change.
- PACK:
  - Limit L = 2^(OUT_WIDTH-1)-1 for s=0, 2^(OUT_WIDTH-1) for s=1.
  - If ovf or mag>L, result saturates: positive -> 2^(OUT_WIDTH-1)-1, negative -> -2^(OUT_WIDTH-1).
  - Otherwise result = s ? -mag : mag, truncated to OUT_WIDTH bits.
  - Go to PUT_Z.
- PUT_Z:
  - Drive o_Z_STB<=1 and o_Z<=result.
  - On an edge where o_Z_STB && i_Z_ACK, drive o_Z_STB<=0 and go to GET_A.
  - o_Z and o_Z_STB stay stable while i_Z_ACK is low, for unbounded cycles.
  - No new operand is accepted until the result is acknowledged.
- Latency, counting the capture edge as edge 0:
  - Normal path: o_Z_STB is first high after edge 6.
  - Special-case path: o_Z_STB is first high after edge 3.
  - o_A_ACK reasserts one edge after the acknowledge edge.
- Back-to-back operation: i_A_STB held high continuously with i_Z_ACK held high continuously gives one result per 9 cycles (normal path).
- i_Z_ACK high while o_Z_STB=0 has no effect.

Test Plan:
- Reset then 3F800000 (1.0), i_Z_ACK=1 -> o_Z=24'h000001, o_Z_STB high 6 edges after capture, o_A_ACK=0 throughout.
- ROUND_MODE=1, in turn 40200000 (2.5), 40600000 (3.5), C0200000 (-2.5), 3F000000 (0.5), 3F400000 (0.75):
  - ROUND_MODE=1 -> 2, 4, -2 (FFFFFE), 0, 1.
  - Same inputs with ROUND_MODE=0 -> 2, 3, -2, 0, 0.
- Saturation:
  - 501502F9 (1e10) -> 7FFFFF.
  - CB000000 (-8388608.0) -> 800000 (exact, no saturation flag needed).
  - 4AFFFFFF (8388607.5), ROUND_MODE=1 -> rounds to 8388608 -> saturates to 7FFFFF.
  - FF800000 (-inf) -> 800000.
- Specials:
  - 7FC00000 (NaN) -> 0.
  - 80000000 (-0.0) -> 0.
  - 00000001 (denormal) -> 0.
  - Each produces o_Z_STB 3 edges after capture.
- Handshake hold:
  - Hold i_Z_ACK=0 for 10 cycles with i_A_STB=1 and i_A changing -> o_Z_STB and o_Z stable, no second capture.
  - Then pulse i_Z_ACK -> o_Z_STB falls, o_A_ACK rises one edge later.
- Assert i_RST asynchronously in SHIFT state -> o_Z_STB=0 and o_A_ACK=0 immediately. After release, the block accepts a new operand and converts it correctly with no stale result.

Source files
------------

// File: rtl/float_to_int.sv
// IEEE-754 single-precision to OUT_WIDTH-bit signed integer converter with STB/ACK handshake.
// Saturates on overflow and infinities; NaN, zero and denormals convert to 0.
module float_to_int #(
  parameter int OUT_WIDTH  = 24,
  parameter int ROUND_MODE = 1
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic [31:0]          i_A,
  input  logic                 i_A_STB,
  output logic                 o_A_ACK,
  output logic [OUT_WIDTH-1:0] o_Z,
  output logic                 o_Z_STB,
  input  logic                 i_Z_ACK
);

  localparam int MW = 34;
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {GET_A, UNPACK, SPECIAL, SHIFT, ROUND, PACK, PUT_Z} state_t;

  state_t                r_state;
  logic [31:0]           r_a;
  logic                  r_s;
  logic [7:0]            r_exp;
  logic [22:0]           r_man;
  logic signed [9:0]     r_e;
  logic [MW-1:0]         r_mag;
  logic                  r_guard;
  logic                  r_sticky;
  logic                  r_ovf;
  logic [OUT_WIDTH-1:0]  r_res;

  logic [MW-1:0]         w_sh_mag;
  logic                  w_sh_g;
  logic                  w_sh_st;
  logic [5:0]            w_amt;
  logic [5:0]            w_amt_m1;

  function automatic logic [MW-1:0] f_round(input logic [MW-1:0] mag, input logic g,
                                            input logic st);
    if (ROUND_MODE == 1 && g && (st || mag[0]))
      return mag + MW'(1);
    return mag;
  endfunction

  // Negative side may reach 2^(OUT_WIDTH-1) exactly, positive side stops one short.
  function automatic logic [OUT_WIDTH-1:0] f_sat(input logic s, input logic ovf,
                                                 input logic [MW-1:0] mag);
    logic [MW-1:0] lim;
    lim = (MW'(1) << (OUT_WIDTH-1)) - MW'(1) + MW'(s);
    if (ovf || mag > lim)
      return s ? SAT_MIN : SAT_MAX;
    return s ? -mag[OUT_WIDTH-1:0] : mag[OUT_WIDTH-1:0];
  endfunction

  always_comb begin
    w_sh_mag = '0;
    w_sh_g   = 1'b0;
    w_sh_st  = 1'b0;
    w_amt    = '0;
    w_amt_m1 = '0;
    if (r_e >= 10'sd23) begin
      w_amt    = 6'(r_e - 10'sd23);
      w_sh_mag = r_mag << w_amt;
    end else if (r_e >= 10'sd0) begin
      w_amt    = 6'(10'sd23 - r_e);
      w_amt_m1 = w_amt - 6'd1;
      w_sh_mag = r_mag >> w_amt;
      w_sh_g   = r_mag[w_amt_m1];
      w_sh_st  = |(r_mag & ((MW'(1) << w_amt_m1) - MW'(1)));
    end else if (r_e == -10'sd1) begin
      w_sh_g  = 1'b1;
      w_sh_st = |r_man;
    end else begin
      w_sh_st = 1'b1;
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_state  <= GET_A;
      o_A_ACK  <= 1'b0;
      o_Z_STB  <= 1'b0;
      o_Z      <= '0;
      r_a      <= '0;
      r_s      <= 1'b0;
      r_exp    <= '0;
      r_man    <= '0;
      r_e      <= '0;
      r_mag    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_ovf    <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        GET_A: begin
          o_A_ACK <= 1'b1;
          if (o_A_ACK && i_A_STB) begin
            r_a     <= i_A;
            o_A_ACK <= 1'b0;
            r_state <= UNPACK;
          end
        end
        UNPACK: begin
          r_s     <= r_a[31];
          r_exp   <= r_a[30:23];
          r_man   <= r_a[22:0];
          r_e     <= $signed({2'b00, r_a[30:23]}) - 10'sd127;
          r_mag   <= {10'b0, 1'b1, r_a[22:0]};
          r_state <= SPECIAL;
        end
        SPECIAL: begin
          if (r_exp == 8'hFF && r_man != '0) begin
            r_res   <= '0;
            r_state <= PUT_Z;
          end else if (r_exp == 8'hFF) begin
            r_res   <= r_s ? SAT_MIN : SAT_MAX;
            r_state <= PUT_Z;
          end else if (r_exp == 8'h00) begin
            r_res   <= '0;
            r_state <= PUT_Z;
          end else begin
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_mag    <= w_sh_mag;
          r_guard  <= w_sh_g;
          r_sticky <= w_sh_st;
          r_ovf    <= (r_e >= 10'sd31);
          r_state  <= ROUND;
        end
        ROUND: begin
          r_mag   <= f_round(r_mag, r_guard, r_sticky);
          r_state <= PACK;
        end
        PACK: begin
          r_res   <= f_sat(r_s, r_ovf, r_mag);
          r_state <= PUT_Z;
        end
        PUT_Z: begin
          o_Z_STB <= 1'b1;
          o_Z     <= r_res;
          if (o_Z_STB && i_Z_ACK) begin
            o_Z_STB <= 1'b0;
            r_state <= GET_A;
          end
        end
        default: r_state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: two instances (round-to-nearest and truncate) driven in lockstep.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic        a_stb;
  logic        z_ack;
  logic        ack1, ack0, stb1, stb0;
  logic [23:0] z1, z0;

  int n_cmp = 0;
  int n_err = 0;

  float_to_int #(.OUT_WIDTH(24), .ROUND_MODE(1)) u_rn (
    .i_CLK(clk), .i_RST(rst), .i_A(a), .i_A_STB(a_stb), .o_A_ACK(ack1),
    .o_Z(z1), .o_Z_STB(stb1), .i_Z_ACK(z_ack));

  float_to_int #(.OUT_WIDTH(24), .ROUND_MODE(0)) u_tz (
    .i_CLK(clk), .i_RST(rst), .i_A(a), .i_A_STB(a_stb), .o_A_ACK(ack0),
    .o_Z(z0), .o_Z_STB(stb0), .i_Z_ACK(z_ack));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge with o_A_ACK back high.
  task automatic conv(input string tag, input logic [31:0] a_v, input logic [23:0] e1,
                      input logic [23:0] e0, input int lat);
    int n;
    int ackhi;
    a = a_v;
    a_stb = 1'b1;
    n = 0;
    while (!ack1 && n < 30) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, 32'(ack1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    a_stb = 1'b0;
    a = 32'hDEADBEEF;
    n = 0;
    ackhi = 0;
    while (!stb1 && n < 30) begin
      if (ack1) ackhi++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_z_rn"}, 32'(z1), 32'(e1));
    chk({tag, "_z_tz"}, {31'b0, stb0} | (32'(z0) << 1), {31'b0, 1'b1} | (32'(e0) << 1));
    chk({tag, "_ack_lo"}, 32'(ackhi), 32'd0);
    @(negedge clk);
    chk({tag, "_stb_fall"}, 32'(stb1), 32'd0);
    @(negedge clk);
    chk({tag, "_ack_rise"}, 32'(ack1), 32'd1);
  endtask

  initial begin
    int n;
    logic stable;
    clk = 1'b0;
    rst = 1'b1;
    a = '0;
    a_stb = 1'b0;
    z_ack = 1'b1;
    #12;
    chk("rst_ack", 32'(ack1), 32'd0);
    chk("rst_stb", 32'(stb1), 32'd0);
    chk("rst_z", 32'(z1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_ack_lo", 32'(ack1), 32'd0);
    @(negedge clk);
    chk("rel_ack_hi", 32'(ack1), 32'd1);

    conv("one",     32'h3F800000, 24'h000001, 24'h000001, 6);
    conv("p2_5",    32'h40200000, 24'h000002, 24'h000002, 6);
    conv("p3_5",    32'h40600000, 24'h000004, 24'h000003, 6);
    conv("m2_5",    32'hC0200000, 24'hFFFFFE, 24'hFFFFFE, 6);
    conv("p0_5",    32'h3F000000, 24'h000000, 24'h000000, 6);
    conv("p0_75",   32'h3F400000, 24'h000001, 24'h000000, 6);
    conv("big",     32'h501502F9, 24'h7FFFFF, 24'h7FFFFF, 6);
    conv("minexact",32'hCB000000, 24'h800000, 24'h800000, 6);
    conv("rnd_sat", 32'h4AFFFFFF, 24'h7FFFFF, 24'h7FFFFF, 6);
    conv("ninf",    32'hFF800000, 24'h800000, 24'h800000, 3);
    conv("nan",     32'h7FC00000, 24'h000000, 24'h000000, 3);
    conv("negzero", 32'h80000000, 24'h000000, 24'h000000, 3);
    conv("denorm",  32'h00000001, 24'h000000, 24'h000000, 3);
    conv("m7",      32'hC0E00000, 24'hFFFFF9, 24'hFFFFF9, 6);

    // Result held while the consumer stalls; new operands must be ignored.
    z_ack = 1'b0;
    a = 32'h3F800000;
    a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'h40600000;
    n = 0;
    while (!stb1 && n < 30) begin @(negedge clk); n++; end
    chk("hold_stb", 32'(stb1), 32'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 32'h40600000 + 32'(i);
      if (!(stb1 && z1 == 24'h000001 && !ack1)) stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    chk("hold_z", 32'(z1), 32'h000001);
    a_stb = 1'b0;
    z_ack = 1'b1;
    @(negedge clk);
    chk("hold_stb_fall", 32'(stb1), 32'd0);
    chk("hold_ack_lo", 32'(ack1), 32'd0);
    @(negedge clk);
    chk("hold_ack_rise", 32'(ack1), 32'd1);

    // Asynchronous reset while in SHIFT.
    a = 32'h40200000;
    a_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_stb", 32'(stb1), 32'd0);
    chk("arst_ack", 32'(ack1), 32'd0);
    chk("arst_z", 32'(z1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_no_stale", 32'(stb1), 32'd0);
    conv("post_rst", 32'h40600000, 24'h000004, 24'h000003, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
